// File: rtl/led_breathe_if.sv
// LED breathing driver port bundle: run enable in, PWM drive and status out.
interface led_breathe_if #(
  parameter int unsigned PWM_W = 8
);
  logic             en;
  logic             led;
  logic [PWM_W-1:0] duty;
  logic [2:0]       state;

  modport master (output en, input led, input duty, input state);
  modport slave  (input en, output led, output duty, output state);
endinterface

// File: rtl/led_breathe.sv
// LED breathing PWM driver: duty ramps up, holds, ramps down, holds, in a loop.
// Optional LED_BREATHE_GAMMA_EN squares the duty index for perceptually linear brightness.
module led_breathe #(
  parameter int unsigned PWM_W        = 8,
  parameter int unsigned STEP_DIV     = 16,
  parameter int unsigned HOLD_PERIODS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  led_breathe_if.slave bus
);

  localparam int unsigned STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

  localparam logic [PWM_W-1:0]  CNT_MAX   = '1;
  localparam logic [PWM_W-1:0]  DUTY_NEAR = CNT_MAX - PWM_W'(1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0]  duty_q, duty_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              led_q, led_d;
  logic [PWM_W-1:0]  cmp;
  logic              period_end;

`ifdef LED_BREATHE_GAMMA_EN
  localparam int unsigned SQ_W = 2 * PWM_W;
  logic [SQ_W-1:0] duty_sq;

  assign duty_sq = SQ_W'(duty_q) * SQ_W'(duty_q);
  assign cmp     = PWM_W'(duty_sq >> PWM_W);
`else
  assign cmp = duty_q;
`endif

  assign period_end = (state_q != IDLE) && (pwm_cnt_q == CNT_MAX);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pwm_cnt_q  <= '0;
      duty_q     <= '0;
      step_cnt_q <= '0;
      hold_cnt_q <= '0;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwm_cnt_q  <= pwm_cnt_d;
      duty_q     <= duty_d;
      step_cnt_q <= step_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      led_q      <= led_d;
    end
  end

  // Next-state, duty stepping and PWM compare
  always_comb begin
    state_d    = state_q;
    pwm_cnt_d  = pwm_cnt_q;
    duty_d     = duty_q;
    step_cnt_d = step_cnt_q;
    hold_cnt_d = hold_cnt_q;
    led_d      = 1'b0;

    if (state_q != IDLE) begin
      pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
      led_d     = (pwm_cnt_q < cmp);
    end

    case (state_q)
      IDLE: begin
        pwm_cnt_d  = '0;
        duty_d     = '0;
        step_cnt_d = '0;
        hold_cnt_d = '0;
        if (bus.en) state_d = RISE;
      end
      RISE: begin
        if (period_end) begin
          if (step_cnt_q == STEP_LAST) begin
            step_cnt_d = '0;
            duty_d     = duty_q + PWM_W'(1);
            if (duty_q == DUTY_NEAR) begin
              state_d    = HOLD_HI;
              hold_cnt_d = '0;
            end
          end else begin
            step_cnt_d = step_cnt_q + STEP_W'(1);
          end
        end
      end
      HOLD_HI: begin
        if (period_end) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d    = FALL;
            step_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end
      FALL: begin
        if (period_end) begin
          if (step_cnt_q == STEP_LAST) begin
            step_cnt_d = '0;
            duty_d     = duty_q - PWM_W'(1);
            if (duty_q == PWM_W'(1)) begin
              state_d    = HOLD_LO;
              hold_cnt_d = '0;
            end
          end else begin
            step_cnt_d = step_cnt_q + STEP_W'(1);
          end
        end
      end
      HOLD_LO: begin
        if (period_end) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d    = RISE;
            step_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A stop at period end overrides any step or hold transition
    if (period_end && !bus.en) begin
      state_d    = IDLE;
      pwm_cnt_d  = '0;
      duty_d     = '0;
      step_cnt_d = '0;
      hold_cnt_d = '0;
    end
  end

  assign bus.led   = led_q;
  assign bus.duty  = duty_q;
  assign bus.state = state_q;

endmodule
